// File: rtl/dac_seg_encoder.sv
// Segmented DAC front end: binary LSB segment plus unary MSB segment with optional
// data-weighted averaging, all outputs registered as true/complement pairs.
module dac_seg_encoder #(
  parameter int DATA_W = 10,
  parameter int BIN_W  = 7,
  localparam int MSB_W   = DATA_W - BIN_W,
  localparam int THERM_W = (2 ** MSB_W) - 1,
  localparam int PTR_W   = (THERM_W > 1) ? $clog2(THERM_W) : 1
) (
  input  logic               clkin,
  input  logic               rstb,
  input  logic               pdb,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_code,
  input  logic               in_fmt,
  input  logic               dwa_en,
  output logic [BIN_W-1:0]   datainbin,
  output logic [BIN_W-1:0]   datainbinb,
  output logic [THERM_W-1:0] dataintherm,
  output logic [THERM_W-1:0] datainthermb,
  output logic [DATA_W-1:0]  code_out,
  output logic [PTR_W-1:0]   dwa_ptr
);

  logic [DATA_W-1:0]  c_reg;
  logic [DATA_W-1:0]  c_next;
  logic [MSB_W-1:0]   k;
  logic [PTR_W:0]     ptr_sum;
  logic [PTR_W-1:0]   ptr_next;
  logic [THERM_W-1:0] therm_fix;
  logic [THERM_W-1:0] therm_rot;
  logic [THERM_W-1:0] therm_sel;

  // Two's complement input becomes offset binary by flipping the sign bit.
  always_comb begin
    c_next = c_reg;
    if (in_valid) begin
      c_next = {in_code[DATA_W-1] ^ in_fmt, in_code[DATA_W-2:0]};
    end
  end

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      c_reg <= '0;
    end else if (!pdb) begin
      c_reg <= '0;
    end else begin
      c_reg <= c_next;
    end
  end

  assign k = c_reg[DATA_W-1:BIN_W];

  // k is at most THERM_W, so one conditional subtract brings p+k back into range.
  always_comb begin
    ptr_sum  = {1'b0, dwa_ptr} + (PTR_W + 1)'(k);
    ptr_next = ptr_sum[PTR_W-1:0];
    if (ptr_sum >= (PTR_W + 1)'(THERM_W)) begin
      ptr_next = PTR_W'(ptr_sum - (PTR_W + 1)'(THERM_W));
    end
  end

  // Element gi is on when its distance forward from the pointer is below k.
  for (genvar gi = 0; gi < THERM_W; gi++) begin : g_elem
    logic [PTR_W:0] offset;

    always_comb begin
      if ((PTR_W + 1)'(gi) >= {1'b0, dwa_ptr}) begin
        offset = (PTR_W + 1)'(gi) - {1'b0, dwa_ptr};
      end else begin
        offset = (PTR_W + 1)'(gi) + (PTR_W + 1)'(THERM_W) - {1'b0, dwa_ptr};
      end
    end

    assign therm_fix[gi] = (MSB_W + 1)'(gi) < {1'b0, k};
    assign therm_rot[gi] = offset < (PTR_W + 1)'(k);
  end

  assign therm_sel = dwa_en ? therm_rot : therm_fix;

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      datainbin    <= '0;
      datainbinb   <= '1;
      dataintherm  <= '0;
      datainthermb <= '1;
      code_out     <= '0;
      dwa_ptr      <= '0;
    end else if (!pdb) begin
      datainbin    <= '0;
      datainbinb   <= '1;
      dataintherm  <= '0;
      datainthermb <= '1;
      code_out     <= '0;
      dwa_ptr      <= '0;
    end else begin
      datainbin    <= c_reg[BIN_W-1:0];
      datainbinb   <= ~c_reg[BIN_W-1:0];
      dataintherm  <= therm_sel;
      datainthermb <= ~therm_sel;
      code_out     <= c_reg;
      // A held sample keeps rotating; the pointer only freezes when DWA is off.
      if (dwa_en) begin
        dwa_ptr <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_dac_seg_encoder.sv
// Directed, table-driven bench for dac_seg_encoder: fixed-thermometer vectors,
// DWA rotation, power-down and asynchronous reset sequences.
module tb_dac_seg_encoder;

  logic       clkin = 1'b0;
  logic       rstb;
  logic       pdb;
  logic       in_valid;
  logic [9:0] in_code;
  logic       in_fmt;
  logic       dwa_en;
  logic [6:0] datainbin;
  logic [6:0] datainbinb;
  logic [6:0] dataintherm;
  logic [6:0] datainthermb;
  logic [9:0] code_out;
  logic [2:0] dwa_ptr;

  int tests = 0;
  int fails = 0;

  dac_seg_encoder #(.DATA_W(10), .BIN_W(7)) dut (
    .clkin        (clkin),
    .rstb         (rstb),
    .pdb          (pdb),
    .in_valid     (in_valid),
    .in_code      (in_code),
    .in_fmt       (in_fmt),
    .dwa_en       (dwa_en),
    .datainbin    (datainbin),
    .datainbinb   (datainbinb),
    .dataintherm  (dataintherm),
    .datainthermb (datainthermb),
    .code_out     (code_out),
    .dwa_ptr      (dwa_ptr)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [9:0] code;
    logic       fmt;
    logic [6:0] e_bin;
    logic [6:0] e_therm;
    logic [9:0] e_code;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] eb, input logic [6:0] et,
                       input logic [9:0] ec, input logic [2:0] ep);
    logic [6:0] ebb;
    logic [6:0] etb;
    ebb = ~eb;
    etb = ~et;
    tests++;
    if (datainbin !== eb || datainbinb !== ebb || dataintherm !== et ||
        datainthermb !== etb || code_out !== ec || dwa_ptr !== ep) begin
      fails++;
      $display("FAIL %s: got bin=%h binb=%h therm=%h thermb=%h code=%h ptr=%0d; need bin=%h binb=%h therm=%h thermb=%h code=%h ptr=%0d",
               name, datainbin, datainbinb, dataintherm, datainthermb, code_out, dwa_ptr,
               eb, ebb, et, etb, ec, ep);
    end else begin
      $display("[TB] ok %s: bin=%h therm=%h code=%h ptr=%0d", name, datainbin, dataintherm,
               code_out, dwa_ptr);
    end
  endtask

  task automatic do_reset();
    rstb     = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    rstb = 1'b1;
  endtask

  initial begin
    logic [6:0] prev_bin;
    logic [6:0] prev_therm;
    logic [9:0] prev_code;
    logic [6:0] one_hot;

    vecs[0] = '{10'h3FF, 1'b0, 7'h7F, 7'h7F, 10'h3FF};
    vecs[1] = '{10'h180, 1'b0, 7'h00, 7'h07, 10'h180};
    vecs[2] = '{10'h000, 1'b1, 7'h00, 7'h0F, 10'h200};
    vecs[3] = '{10'h3FF, 1'b1, 7'h7F, 7'h07, 10'h1FF};
    vecs[4] = '{10'h2A5, 1'b0, 7'h25, 7'h1F, 10'h2A5};
    vecs[5] = '{10'h07F, 1'b0, 7'h7F, 7'h00, 10'h07F};
    vecs[6] = '{10'h155, 1'b1, 7'h55, 7'h3F, 10'h355};
    vecs[7] = '{10'h100, 1'b0, 7'h00, 7'h03, 10'h100};
    vecs[8] = '{10'h000, 1'b0, 7'h00, 7'h00, 10'h000};

    // Reset with full-scale input present: nothing may leak through.
    rstb     = 1'b0;
    pdb      = 1'b1;
    in_valid = 1'b1;
    in_code  = 10'h3FF;
    in_fmt   = 1'b0;
    dwa_en   = 1'b0;
    step();
    step();
    check("reset", 7'h00, 7'h00, 10'h000, 3'd0);
    rstb     = 1'b1;
    in_valid = 1'b0;

    // Fixed thermometer vectors; the first edge must still show the previous sample.
    prev_bin   = 7'h00;
    prev_therm = 7'h00;
    prev_code  = 10'h000;
    for (int i = 0; i < 9; i++) begin
      in_code  = vecs[i].code;
      in_fmt   = vecs[i].fmt;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d_latency", i), prev_bin, prev_therm, prev_code, 3'd0);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_bin, vecs[i].e_therm, vecs[i].e_code, 3'd0);
      prev_bin   = vecs[i].e_bin;
      prev_therm = vecs[i].e_therm;
      prev_code  = vecs[i].e_code;
    end
    in_fmt = 1'b0;

    // DWA with three back-to-back samples of k=3.
    do_reset();
    dwa_en   = 1'b1;
    in_code  = 10'h180;
    in_valid = 1'b1;
    step();
    check("dwa3_fill", 7'h00, 7'h00, 10'h000, 3'd0);
    step();
    check("dwa3_a", 7'h00, 7'h07, 10'h180, 3'd3);
    step();
    check("dwa3_b", 7'h00, 7'h38, 10'h180, 3'd6);
    in_valid = 1'b0;
    step();
    check("dwa3_c", 7'h00, 7'h43, 10'h180, 3'd2);

    // Held k=1 sample keeps rotating a single element every clock.
    do_reset();
    dwa_en   = 1'b1;
    in_code  = 10'h080;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      one_hot = 7'h01 << (i % 7);
      check($sformatf("rot%0d", i), 7'h00, one_hot, 10'h080, 3'((i + 1) % 7));
    end

    // Power-down with pointer at 5; in_valid must be ignored while down.
    pdb      = 1'b0;
    step();
    check("pd_enter", 7'h00, 7'h00, 10'h000, 3'd0);
    in_valid = 1'b1;
    in_code  = 10'h3FF;
    step();
    check("pd_ignore_valid", 7'h00, 7'h00, 10'h000, 3'd0);
    pdb      = 1'b1;
    in_valid = 1'b0;
    step();
    check("pd_exit_zero", 7'h00, 7'h00, 10'h000, 3'd0);
    in_code  = 10'h2A5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("pd_first_sample", 7'h25, 7'h1F, 10'h2A5, 3'd5);

    // DWA off freezes the pointer; back on resumes from it.
    dwa_en = 1'b0;
    step();
    check("dwa_freeze", 7'h25, 7'h1F, 10'h2A5, 3'd5);
    dwa_en = 1'b1;
    step();
    check("dwa_resume", 7'h25, 7'h67, 10'h2A5, 3'd3);

    // Asynchronous reset mid-stream takes effect before the next edge.
    #2;
    rstb = 1'b0;
    #1;
    check("async_reset", 7'h00, 7'h00, 10'h000, 3'd0);
    step();
    rstb     = 1'b1;
    dwa_en   = 1'b0;
    in_code  = 10'h3FF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_reset_latency", 7'h00, 7'h00, 10'h000, 3'd0);
    step();
    check("post_reset_sample", 7'h7F, 7'h7F, 10'h3FF, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
